inv_output_sequencer: RTL

INV_OUTPUT_SEQUENCER -- requirements
Module: inv_output_sequencer

---
 rtl/inv_seq_pkg.sv | 29 ++
 rtl/flt_debounce.sv | 40 ++++
 rtl/inv_output_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/inv_seq_pkg.sv
// Shared definitions for the inverter output sequencer: state encoding,
// default timing constants and the saturating timer helper.
package inv_seq_pkg;

    // Sequencer states; codes 5..7 are unused and recover to ST_FAULT.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLOSE    = 3'd1,
        ST_RUN      = 3'd2,
        ST_STOPPING = 3'd3,
        ST_FAULT    = 3'd4
    } seq_state_t;

    // Default timing, in CLK0 cycles at 50 MHz.
    localparam int DEF_DEB_CNT = 50;      // 1 us fault qualification
    localparam int DEF_T_CLOSE = 50000;   // contactor close -> PWM enable
    localparam int DEF_T_OPEN  = 50000;   // PWM disable -> contactor open
    localparam int DEF_T_TRIP  = 25000;   // breaker trip pulse width
    localparam int DEF_INT_W   = 500;     // DSP interrupt pulse width

    localparam int TMR_W = 16;            // single shared state timer width
    localparam int N_FLT = 4;             // bridge A/B/C + overtemperature

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [TMR_W-1:0] tmr_sat_inc(input logic [TMR_W-1:0] val);
        return (val == {TMR_W{1'b1}}) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/flt_debounce.sv
// Single-bit fault qualifier: the output rises once the raw input has been
// high for DEB_CNT consecutive samples and drops on the first low sample.
module flt_debounce
#(
    parameter int DEB_CNT = 50
)
(
    input  logic CLK0,
    input  logic RSTn,
    input  logic RAW,
    output logic QUAL
);

    localparam int CNT_W = $clog2(DEB_CNT + 1);
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CNT);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             qual_reg;

    // Count consecutive high samples; any low sample restarts the count.
    always_ff @(posedge CLK0) begin
        if (!RSTn) begin
            cnt_reg  <= '0;
            qual_reg <= 1'b0;
        end else if (!RAW) begin
            cnt_reg  <= '0;
            qual_reg <= 1'b0;
        end else begin
            if (cnt_reg != DEB_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            // This sample is the DEB_CNT-th (or later) consecutive high one.
            qual_reg <= (cnt_reg >= DEB_LAST);
        end
    end

    assign QUAL = qual_reg;

endmodule

// File: rtl/inv_output_sequencer.sv
// Inverter output sequencer: orders contactor close / PWM enable on start,
// PWM disable / contactor open on stop, trips the breaker on any qualified
// fault and pulses INT1 to the DSP on every state change.
module inv_output_sequencer
    import inv_seq_pkg::*;
#(
    parameter int DEB_CNT = DEF_DEB_CNT,
    parameter int T_CLOSE = DEF_T_CLOSE,
    parameter int T_OPEN  = DEF_T_OPEN,
    parameter int T_TRIP  = DEF_T_TRIP,
    parameter int INT_W   = DEF_INT_W
)
(
    input  logic       CLK0,
    input  logic       RSTn,
    input  logic       START_REQ,
    input  logic       STOP_REQ,
    input  logic       FLT_CLR,
    input  logic [3:0] FAULT_IN,
    output logic       CONTACTOR_ON,
    output logic       PWM_EN,
    output logic       BREAKER_TRIP,
    output logic [2:0] STATE,
    output logic [3:0] FAULT_CODE,
    output logic       INT1
);

    // Timer values on the last cycle of a timed state, and pulse lengths.
    localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(T_CLOSE - 1);
    localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(T_OPEN - 1);
    localparam logic [TMR_W-1:0] TRIP_LEN   = TMR_W'(T_TRIP);
    localparam logic [TMR_W-1:0] INT_LAST   = TMR_W'(INT_W - 1);

    logic [N_FLT-1:0] flt_qual;
    logic             any_flt;

    seq_state_t       state_reg;
    seq_state_t       state_next;
    logic [TMR_W-1:0] timer_reg;
    logic [TMR_W-1:0] timer_next;
    logic             contactor_reg;
    logic             pwm_reg;
    logic             trip_reg;
    logic [3:0]       fault_code_reg;
    logic             chg_reg;
    logic [TMR_W-1:0] int_cnt_reg;
    logic             int1_reg;

    // One qualifier per raw fault input.
    generate
        for (genvar gi = 0; gi < N_FLT; gi++) begin : g_deb
            flt_debounce #(
                .DEB_CNT (DEB_CNT)
            ) u_flt_debounce (
                .CLK0 (CLK0),
                .RSTn (RSTn),
                .RAW  (FAULT_IN[gi]),
                .QUAL (flt_qual[gi])
            );
        end
    endgenerate

    assign any_flt = |flt_qual;

    // Next-state decode: fault beats stop, stop beats start.
    always_comb begin
        state_next = state_reg;
        if ((state_reg != ST_FAULT) && any_flt) begin
            state_next = ST_FAULT;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (START_REQ && !STOP_REQ) begin
                        state_next = ST_CLOSE;
                    end
                end
                ST_CLOSE: begin
                    if (STOP_REQ) begin
                        state_next = ST_STOPPING;
                    end else if (timer_reg == CLOSE_LAST) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (STOP_REQ) begin
                        state_next = ST_STOPPING;
                    end
                end
                ST_STOPPING: begin
                    if (timer_reg == OPEN_LAST) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    // Clear only once the trip pulse is over and nothing is qualified.
                    if (FLT_CLR && !trip_reg && !any_flt) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_FAULT;
                end
            endcase
        end
    end

    // The timer restarts from zero on every state entry.
    assign timer_next = (state_next != state_reg) ? '0 : tmr_sat_inc(timer_reg);

    // State, timer and all outputs registered from the decoded next state.
    always_ff @(posedge CLK0) begin
        if (!RSTn) begin
            state_reg      <= ST_IDLE;
            timer_reg      <= '0;
            contactor_reg  <= 1'b0;
            pwm_reg        <= 1'b0;
            trip_reg       <= 1'b0;
            fault_code_reg <= '0;
            chg_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            contactor_reg  <= (state_next == ST_CLOSE) || (state_next == ST_RUN) ||
                              (state_next == ST_STOPPING);
            pwm_reg        <= (state_next == ST_RUN);
            trip_reg       <= (state_next == ST_FAULT) && (timer_next < TRIP_LEN);
            // Accumulate qualified faults while in FAULT; leaving FAULT clears them.
            fault_code_reg <= (state_next == ST_FAULT) ? (fault_code_reg | flt_qual) : '0;
            chg_reg        <= (state_next != state_reg);
        end
    end

    // DSP interrupt: starts the cycle after a state change, restarts on a new change.
    always_ff @(posedge CLK0) begin
        if (!RSTn) begin
            int1_reg    <= 1'b0;
            int_cnt_reg <= '0;
        end else if (chg_reg) begin
            int1_reg    <= 1'b1;
            int_cnt_reg <= INT_LAST;
        end else if (int_cnt_reg != '0) begin
            int_cnt_reg <= int_cnt_reg - 1'b1;
        end else begin
            int1_reg <= 1'b0;
        end
    end

    assign CONTACTOR_ON = contactor_reg;
    assign PWM_EN       = pwm_reg;
    assign BREAKER_TRIP = trip_reg;
    assign STATE        = state_reg;
    assign FAULT_CODE   = fault_code_reg;
    assign INT1         = int1_reg;

endmodule
